// File: rtl/note_player_if.sv
// Song RAM read port between the note player and the shared 8192x28 RAM.
// rd_data is valid one cycle after rd_address changes.
interface note_player_if;
    logic [12:0] rd_address;
    logic [27:0] rd_data;

    modport master (output rd_address, input rd_data);
    modport slave  (input rd_address, output rd_data);
endinterface

// File: rtl/note_player.sv
// Replays {key, start, duration} note records from the song RAM against a
// 0.01 s playback clock, driving the active key and a square-wave tone.
module note_player #(
    parameter int TICK_DIV  = 500000,
    parameter int HALF_DO   = 95556,
    parameter int HALF_RE   = 85131,
    parameter int HALF_MI   = 75843,
    parameter int LAST_ADDR = 8191
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic          stop,
    note_player_if.master ram,
    output logic [1:0]    active_key,
    output logic          audio_out,
    output logic [12:0]   play_time,
    output logic          busy,
    output logic          done
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [12:0] LAST = 13'(LAST_ADDR);
    localparam int HMAX_DR = (HALF_DO > HALF_RE) ? HALF_DO : HALF_RE;
    localparam int HMAX = (HMAX_DR > HALF_MI) ? HMAX_DR : HALF_MI;
    localparam int HW = $clog2(HMAX + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LATCH, WAIT_START, SOUNDING, FINISH
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] tone_cnt;
    logic [HW-1:0] half;
    logic [1:0]    key_r;
    logic [12:0]   start_r;
    logic [12:0]   dur_r;
    logic [12:0]   remaining;
    logic          tick;
    logic          at_last;
    logic [1:0]    q_key;
    logic [12:0]   q_dur;

    assign tick    = (tick_cnt == '0);
    assign at_last = (ram.rd_address == LAST);
    assign q_key   = ram.rd_data[27:26];
    assign q_dur   = ram.rd_data[12:0];

    always_comb begin
        half = HW'(HALF_DO);
        case (active_key)
            2'b10:   half = HW'(HALF_RE);
            2'b11:   half = HW'(HALF_MI);
            default: half = HW'(HALF_DO);
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ram.rd_address <= '0;
            active_key     <= '0;
            audio_out      <= 1'b0;
            play_time      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            tick_cnt       <= '0;
            tone_cnt       <= '0;
            key_r          <= '0;
            start_r        <= '0;
            dur_r          <= '0;
            remaining      <= '0;
        end else begin
            done <= 1'b0;

            // Playback clock; an abort freezes play_time at its last value.
            if (busy && !stop) begin
                if (tick) begin
                    tick_cnt <= TICK_MAX;
                    if (play_time != 13'h1fff)
                        play_time <= play_time + 13'd1;
                end else begin
                    tick_cnt <= tick_cnt - 1'b1;
                end
            end

            if (active_key == 2'b00) begin
                tone_cnt  <= '0;
                audio_out <= 1'b0;
            end else if (tone_cnt == half - 1'b1) begin
                tone_cnt  <= '0;
                audio_out <= ~audio_out;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end

            if (busy && stop) begin
                state      <= FINISH;
                busy       <= 1'b0;
                done       <= 1'b1;
                active_key <= '0;
                audio_out  <= 1'b0;
                tone_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state          <= FETCH;
                            busy           <= 1'b1;
                            ram.rd_address <= '0;
                            play_time      <= '0;
                            tick_cnt       <= TICK_MAX;
                        end
                    end
                    FETCH: state <= LATCH;
                    LATCH: begin
                        {key_r, start_r, dur_r} <= ram.rd_data;
                        if (q_key == 2'b00) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (q_dur == '0) begin
                            if (at_last) begin
                                state <= FINISH;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state          <= FETCH;
                                ram.rd_address <= ram.rd_address + 13'd1;
                            end
                        end else begin
                            state <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (play_time >= start_r) begin
                            state      <= SOUNDING;
                            remaining  <= dur_r;
                            active_key <= key_r;
                            tone_cnt   <= '0;
                            audio_out  <= 1'b0;
                        end
                    end
                    SOUNDING: begin
                        if (tick && remaining == 13'd1) begin
                            active_key <= '0;
                            audio_out  <= 1'b0;
                            tone_cnt   <= '0;
                            if (at_last) begin
                                state <= FINISH;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state          <= FETCH;
                                ram.rd_address <= ram.rd_address + 13'd1;
                            end
                        end else if (tick) begin
                            remaining <= remaining - 13'd1;
                        end
                    end
                    FINISH:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_player.sv
// Bench for note_player: directed and random songs checked against a
// note-level model of onset/release play times, tone phase and finish.
module tb_note_player;
    localparam int TD  = 4;
    localparam int HDO = 3;
    localparam int HRE = 5;
    localparam int HMI = 7;

    typedef struct {int key; int st; int dur;} rec_t;
    typedef struct {int key; int on; int off;} ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  key1, key2;
    logic        aud1, aud2, busy1, busy2, done1, done2;
    logic [12:0] pt1, pt2;
    logic [27:0] ram1 [0:8191];
    logic [27:0] ram2 [0:3];

    note_player_if bus1();
    note_player_if bus2();

    always #5 clk = ~clk;

    always @(posedge clk) bus1.rd_data <= ram1[bus1.rd_address];
    always @(posedge clk) bus2.rd_data <= ram2[bus2.rd_address[1:0]];

    note_player #(
        .TICK_DIV(TD), .HALF_DO(HDO), .HALF_RE(HRE), .HALF_MI(HMI)
    ) dut1 (
        .clock(clk), .reset_n(rst_n), .start(start), .stop(stop),
        .ram(bus1), .active_key(key1), .audio_out(aud1),
        .play_time(pt1), .busy(busy1), .done(done1)
    );

    note_player #(
        .TICK_DIV(TD), .HALF_DO(HDO), .HALF_RE(HRE), .HALF_MI(HMI),
        .LAST_ADDR(1)
    ) dut2 (
        .clock(clk), .reset_n(rst_n), .start(start), .stop(stop),
        .ram(bus2), .active_key(key2), .audio_out(aud2),
        .play_time(pt2), .busy(busy2), .done(done2)
    );

    int          sel = 1;
    logic [1:0]  s_key;
    logic        s_aud, s_busy, s_done;
    logic [12:0] s_pt, s_addr;

    always_comb begin
        s_key  = key1;
        s_aud  = aud1;
        s_busy = busy1;
        s_done = done1;
        s_pt   = pt1;
        s_addr = bus1.rd_address;
        if (sel == 2) begin
            s_key  = key2;
            s_aud  = aud2;
            s_busy = busy2;
            s_done = done2;
            s_pt   = pt2;
            s_addr = bus2.rd_address;
        end
    end

    int   errors = 0;
    int   checks = 0;
    rec_t recs[$];
    ev_t  exp_q[$];
    int   exp_last;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int half_of(input logic [1:0] k);
        case (k)
            2'b10:   return HRE;
            2'b11:   return HMI;
            default: return HDO;
        endcase
    endfunction

    // Note-level model: a record sounds from max(start, end of previous
    // note) for duration ticks; zero duration is skipped, key 0 ends.
    task automatic load(input int which, input int last);
        int   cur;
        rec_t r;
        ev_t  e;
        cur = 0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) ram1[i] = '0;
        for (int i = 0; i < 4; i++) ram2[i] = '0;
        foreach (recs[i]) begin
            if (which == 1) ram1[i] = {2'(recs[i].key), 13'(recs[i].st), 13'(recs[i].dur)};
            else ram2[i] = {2'(recs[i].key), 13'(recs[i].st), 13'(recs[i].dur)};
        end
        exp_last = 0;
        for (int i = 0; i < 8192; i++) begin
            r = '{0, 0, 0};
            if (i < recs.size()) r = recs[i];
            if (r.key == 0) begin
                exp_last = i;
                break;
            end
            if (r.dur != 0) begin
                e.key = r.key;
                e.on  = (r.st > cur) ? r.st : cur;
                e.off = e.on + r.dur;
                exp_q.push_back(e);
                cur = e.off;
            end
            if (i == last) begin
                exp_last = i;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_song(input int which, input string tag);
        int         idx, n, aud_bad, want;
        bit         got;
        logic [1:0] prev;
        idx = 0; n = 0; aud_bad = 0; got = 0; prev = 2'b00;
        sel = which;
        pulse_start();
        check({tag, "/busy_start"}, 32'(s_busy), 1);
        check({tag, "/addr_start"}, 32'(s_addr), 0);
        check({tag, "/pt_start"}, 32'(s_pt), 0);
        for (int c = 0; c < 3000; c++) begin
            if (s_key !== prev) begin
                if (prev != 2'b00 && idx < exp_q.size()) begin
                    check({tag, "/off_pt"}, 32'(s_pt), 32'(exp_q[idx].off));
                    idx++;
                end
                if (s_key != 2'b00) begin
                    if (idx < exp_q.size()) begin
                        check({tag, "/key"}, 32'(s_key), 32'(exp_q[idx].key));
                        check({tag, "/on_pt"}, 32'(s_pt), 32'(exp_q[idx].on));
                    end else begin
                        check({tag, "/extra_key"}, 32'(s_key), 0);
                    end
                    n = 0;
                end
                prev = s_key;
            end
            want = (s_key == 2'b00) ? 0 : ((n / half_of(s_key)) % 2);
            if (s_aud !== 1'(want)) aud_bad++;
            n++;
            if (s_done === 1'b1) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "/done_seen"}, 32'(got), 1);
        check({tag, "/notes"}, 32'(idx), 32'(exp_q.size()));
        check({tag, "/audio"}, 32'(aud_bad), 0);
        check({tag, "/busy_end"}, 32'(s_busy), 0);
        check({tag, "/addr_end"}, 32'(s_addr), 32'(exp_last));
        @(negedge clk);
        check({tag, "/done_once"}, 32'(s_done), 0);
        check({tag, "/addr_hold"}, 32'(s_addr), 32'(exp_last));
    endtask

    task automatic wait_key(input string tag);
        bit seen;
        seen = 0;
        for (int c = 0; c < 500; c++) begin
            if (s_key != 2'b00) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "/key_on"}, 32'(seen), 1);
    endtask

    task automatic rand_song();
        int   cur, nrec;
        bit   skipped;
        rec_t r;
        recs.delete();
        cur = 0;
        skipped = 0;
        nrec = $urandom_range(3, 7);
        for (int i = 0; i < nrec; i++) begin
            r.key = $urandom_range(1, 3);
            if (!skipped && $urandom_range(0, 3) == 0) r.dur = 0;
            else r.dur = $urandom_range(1, 3);
            if (skipped || $urandom_range(0, 2) != 0) r.st = cur + $urandom_range(1, 3);
            else r.st = $urandom_range(0, cur);
            if (r.dur != 0) cur = ((r.st > cur) ? r.st : cur) + r.dur;
            skipped = (r.dur == 0);
            recs.push_back(r);
        end
    endtask

    initial begin
        logic [12:0] pt_hold;
        int          dn;
        bit          saw3;
        for (int i = 0; i < 8192; i++) ram1[i] = '0;
        for (int i = 0; i < 4; i++) ram2[i] = '0;
        repeat (3) @(negedge clk);
        check("rst/key", 32'(key1), 0);
        check("rst/audio", 32'(aud1), 0);
        check("rst/pt", 32'(pt1), 0);
        check("rst/busy", 32'(busy1), 0);
        check("rst/done", 32'(done1), 0);
        check("rst/addr", 32'(bus1.rd_address), 0);
        rst_n = 1'b1;

        recs = '{'{1, 2, 3}};
        load(1, 8191);
        run_song(1, "single");
        recs = '{'{2, 5, 2}, '{3, 1, 2}};
        load(1, 8191);
        run_song(1, "past_start");
        recs = '{'{1, 0, 0}, '{3, 3, 1}};
        load(1, 8191);
        run_song(1, "zero_dur");
        for (int s = 0; s < 6; s++) begin
            rand_song();
            load(1, 8191);
            run_song(1, $sformatf("rand%0d", s));
        end

        recs = '{'{1, 1, 5}};
        load(1, 8191);
        sel = 1;
        pulse_start();
        wait_key("stop");
        repeat (2) @(negedge clk);
        pt_hold = pt1;
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        check("stop/key", 32'(key1), 0);
        check("stop/audio", 32'(aud1), 0);
        check("stop/done", 32'(done1), 1);
        check("stop/busy", 32'(busy1), 0);
        check("stop/pt_hold", 32'(pt1), 32'(pt_hold));
        @(negedge clk);
        check("stop/done_once", 32'(done1), 0);
        run_song(1, "replay");

        recs = '{'{2, 1, 4}};
        load(1, 8191);
        pulse_start();
        wait_key("rst_mid");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid/key", 32'(key1), 0);
        check("rst_mid/audio", 32'(aud1), 0);
        check("rst_mid/pt", 32'(pt1), 0);
        check("rst_mid/busy", 32'(busy1), 0);
        check("rst_mid/addr", 32'(bus1.rd_address), 0);
        dn = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done1 !== 1'b0) dn++;
        end
        check("rst_mid/no_done", 32'(dn), 0);
        rst_n = 1'b1;

        recs = '{'{1, 2, 2}, '{3, 6, 1}};
        load(1, 8191);
        pulse_start();
        wait_key("restart");
        pulse_start();
        check("restart/pt_kept", 32'(pt1 >= 13'd2), 1);
        check("restart/busy", 32'(busy1), 1);
        saw3 = 0;
        dn = 0;
        for (int c = 0; c < 500; c++) begin
            if (key1 == 2'b11) saw3 = 1;
            if (done1 === 1'b1) begin
                dn = 1;
                break;
            end
            @(negedge clk);
        end
        check("restart/done", 32'(dn), 1);
        check("restart/saw_key3", 32'(saw3), 1);
        check("restart/addr", 32'(bus1.rd_address), 2);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        recs = '{'{1, 0, 1}, '{2, 1, 1}, '{3, 2, 1}};
        load(2, 1);
        run_song(2, "last_addr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
